// File: rtl/csr_pkg.sv
// Shared CSR addresses, func3 encodings, trap cause codes and mstatus field positions
// for the machine-mode CSR file and its trap controller.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIP_MTIP       = 7;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_IRQ,
    SRC_ILLEGAL,
    SRC_EBREAK,
    SRC_ECALL
  } trap_src_e;

  // Zicsr read-modify-write; the register and immediate forms share func3[1:0].
  function automatic logic [63:0] csr_rmw(input logic [2:0] f3, input logic [63:0] old_v,
                                          input logic [63:0] src_v);
    logic [63:0] res;
    case (f3[1:0])
      2'b01:   res = src_v;
      2'b10:   res = old_v | src_v;
      2'b11:   res = old_v & ~src_v;
      default: res = old_v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Trap priority encoder: selects the trap source, builds mcause, the mstatus value after
// trap entry or mret, and the redirect target.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            en,
  input  logic            mtip,
  input  logic            mtie,
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            illegal,
  input  logic            mret,
  input  logic [XLEN-1:0] mstatus_q,
  input  logic [XLEN-1:0] mtvec_q,
  input  logic [XLEN-1:0] mepc_q,
  output logic            trap,
  output logic            mret_take,
  output logic            evt,
  output logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] mstatus_evt,
  output logic [XLEN-1:0] redirect_addr
);

  trap_src_e src;

  always_comb begin
    src = SRC_NONE;
    if (en && mstatus_q[MSTATUS_MIE] && mtie && mtip) src = SRC_IRQ;
    else if (en && illegal)                           src = SRC_ILLEGAL;
    else if (en && ebreak)                            src = SRC_EBREAK;
    else if (en && ecall)                             src = SRC_ECALL;
  end

  assign trap      = (src != SRC_NONE);
  assign mret_take = en & mret & ~trap;
  assign evt       = trap | mret_take;

  always_comb begin
    cause = '0;
    case (src)
      SRC_IRQ: begin
        cause[XLEN-1] = 1'b1;
        cause[3:0]    = CAUSE_MTI;
      end
      SRC_ILLEGAL: cause[3:0] = CAUSE_ILLEGAL;
      SRC_EBREAK:  cause[3:0] = CAUSE_EBREAK;
      SRC_ECALL:   cause[3:0] = CAUSE_ECALL;
      default:     cause = '0;
    endcase
  end

  always_comb begin
    mstatus_evt = mstatus_q;
    if (trap) begin
      mstatus_evt[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
      mstatus_evt[MSTATUS_MIE]                   = 1'b0;
      mstatus_evt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end else if (mret_take) begin
      mstatus_evt[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      mstatus_evt[MSTATUS_MPIE] = 1'b1;
    end
  end

  assign redirect_addr = mret_take ? mepc_q : mtvec_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with Zicsr execution, trap entry/mret sequencing and registered
// writeback. Define CSR_COUNTERS_EN to add mcycle/minstret (and the high halves on RV32).
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800,
  parameter logic [63:0] MTVEC_RST   = 64'h0,
  parameter logic [63:0] HART_ID     = 64'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            csr_op,
  input  logic [2:0]      func3,
  input  logic [11:0]     csr_a,
  input  logic [4:0]      rs1_a,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [4:0]      rd_a,
  input  logic            rd_w,
  input  logic [XLEN-1:0] pc,
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            illegal,
  input  logic            mret,
  input  logic            retire,
  input  logic            mtip,
  output logic [XLEN-1:0] rd_o,
  output logic            rd_w_o,
  output logic [4:0]      rd_a_o,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_addr,
  output logic            mie_global
);

  localparam logic [XLEN-1:0] MPP_MASK     = {{(XLEN-13){1'b0}}, 2'b11, 11'b0};
  localparam logic [XLEN-1:0] ALIGN4       = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MSTATUS_INIT = MSTATUS_RST[XLEN-1:0] | MPP_MASK;
  localparam logic [XLEN-1:0] MTVEC_INIT   = MTVEC_RST[XLEN-1:0] & ALIGN4;

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] rd_q;
  logic            rd_w_q;
  logic [4:0]      rd_a_q;

  logic [XLEN-1:0] src, rdata, wdata;
  logic [63:0]     wdata64;
  logic            csr_wr;
  logic            trap, mret_take, evt;
  logic [XLEN-1:0] cause, mstatus_evt, evt_addr;

  csr_trap_ctrl #(.XLEN(XLEN)) u_ctrl (
    .en            (en),
    .mtip          (mtip),
    .mtie          (mie_q[MIE_MTIE]),
    .ecall         (ecall),
    .ebreak        (ebreak),
    .illegal       (illegal),
    .mret          (mret),
    .mstatus_q     (mstatus_q),
    .mtvec_q       (mtvec_q),
    .mepc_q        (mepc_q),
    .trap          (trap),
    .mret_take     (mret_take),
    .evt           (evt),
    .cause         (cause),
    .mstatus_evt   (mstatus_evt),
    .redirect_addr (evt_addr)
  );

  assign src     = func3[2] ? {{(XLEN-5){1'b0}}, rs1_a} : rs1_val;
  assign wdata64 = csr_rmw(func3, 64'(rdata), 64'(src));
  assign wdata   = wdata64[XLEN-1:0];

  // rs/rc with rs1_a == 0 are pure reads; a taken trap squashes the write.
  assign csr_wr = en & csr_op & ~trap & (func3[1:0] != 2'b00) & ~(func3[1] & (rs1_a == 5'd0));

`ifdef CSR_COUNTERS_EN
  localparam logic [63:0] LO_KEEP = (XLEN == 32) ? 64'hFFFF_FFFF_0000_0000 : 64'h0;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, en & retire};
    if (csr_wr && csr_a == CSR_MCYCLE)                   mcycle_d = (mcycle_q & LO_KEEP) | wdata64;
    if (csr_wr && csr_a == CSR_MCYCLEH && XLEN == 32)    mcycle_d = {wdata64[31:0], mcycle_q[31:0]};
    if (csr_wr && csr_a == CSR_MINSTRET)                 minstret_d = (minstret_q & LO_KEEP) | wdata64;
    if (csr_wr && csr_a == CSR_MINSTRETH && XLEN == 32)  minstret_d = {wdata64[31:0], minstret_q[31:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  always_comb begin
    rdata = '0;
    case (csr_a)
      CSR_MSTATUS:  rdata = mstatus_q;
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MIP:      rdata[MIP_MTIP] = mtip;
      CSR_MHARTID:  rdata = HART_ID[XLEN-1:0];
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    rdata = mcycle_q[XLEN-1:0];
      CSR_MINSTRET:  rdata = minstret_q[XLEN-1:0];
      // The upper-slice form only yields the high word when XLEN is 32.
      CSR_MCYCLEH:   if (XLEN == 32) rdata = mcycle_q[63:64-XLEN];
      CSR_MINSTRETH: if (XLEN == 32) rdata = minstret_q[63:64-XLEN];
`endif
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (csr_wr) begin
      case (csr_a)
        CSR_MSTATUS:  mstatus_d = wdata | MPP_MASK;
        CSR_MIE: begin
          mie_d           = '0;
          mie_d[MIE_MTIE] = wdata[MIE_MTIE];
        end
        CSR_MTVEC:    mtvec_d    = wdata & ALIGN4;
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = wdata & ALIGN4;
        CSR_MCAUSE:   mcause_d   = wdata;
        default:      ;
      endcase
    end
    if (evt) mstatus_d = mstatus_evt;
    if (trap) begin
      mepc_d   = pc & ALIGN4;
      mcause_d = cause;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_INIT;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_INIT;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      rd_q       <= '0;
      rd_w_q     <= 1'b0;
      rd_a_q     <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      rd_w_q     <= en & rd_w & csr_op & ~trap;
      if (en) begin
        rd_q   <= rdata;
        rd_a_q <= rd_a;
      end
    end
  end

  assign rd_o          = rd_q;
  assign rd_w_o        = rd_w_q;
  assign rd_a_o        = rd_a_q;
  assign redirect      = rst_n & evt;
  assign redirect_addr = evt_addr;
  assign mie_global    = mstatus_q[MSTATUS_MIE];

endmodule

// File: tb/tb_csr_trap_unit.sv
// Table-driven bench for csr_trap_unit: each record drives one cycle, expected writeback
// goes through a scoreboard queue and is compared after the next rising edge.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n, en, csr_op, rd_w, ecall, ebreak, illegal, mret, retire, mtip;
  logic [2:0]  func3;
  logic [11:0] csr_a;
  logic [4:0]  rs1_a, rd_a;
  logic [63:0] rs1_val, pc;
  logic [63:0] rd_o, redirect_addr;
  logic        rd_w_o, redirect, mie_global;
  logic [4:0]  rd_a_o;

  always #5 clk = ~clk;

  csr_trap_unit #(.XLEN(64), .HART_ID(64'h3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .csr_op(csr_op), .func3(func3), .csr_a(csr_a),
    .rs1_a(rs1_a), .rs1_val(rs1_val), .rd_a(rd_a), .rd_w(rd_w), .pc(pc), .ecall(ecall),
    .ebreak(ebreak), .illegal(illegal), .mret(mret), .retire(retire), .mtip(mtip),
    .rd_o(rd_o), .rd_w_o(rd_w_o), .rd_a_o(rd_a_o), .redirect(redirect),
    .redirect_addr(redirect_addr), .mie_global(mie_global)
  );

  typedef struct {
    string       name;
    bit          rst, en, csr_op, rdw, ecall, ebreak, illegal, mret, retire, mtip;
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  rs1a, rda;
    logic [63:0] val, pc;
    bit          x_redir, x_rdw, chk_rd;
    logic [63:0] x_raddr, x_rd;
    logic [4:0]  x_rda;
    int          x_mg;
  } vec_t;

  typedef struct {
    string       name;
    bit          rdw, chk;
    logic [63:0] rd;
    logic [4:0]  rda;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [63:0] MS_RST = 64'h0000_000a_0000_1800;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t v_idle(input string n);
    vec_t v;
    v.name = n; v.rst = 0; v.en = 0; v.csr_op = 0; v.rdw = 0; v.ecall = 0; v.ebreak = 0;
    v.illegal = 0; v.mret = 0; v.retire = 0; v.mtip = 0; v.f3 = 3'b000; v.a = 12'h000;
    v.rs1a = 5'd0; v.rda = 5'd0; v.val = 64'd0; v.pc = 64'd0; v.x_redir = 0; v.x_rdw = 0;
    v.chk_rd = 0; v.x_raddr = 64'd0; v.x_rd = 64'd0; v.x_rda = 5'd0; v.x_mg = -1;
    return v;
  endfunction

  function automatic vec_t v_csr(input string n, input logic [2:0] f3, input logic [11:0] a,
                                 input logic [4:0] rs1a, input logic [63:0] val,
                                 input logic [63:0] exp);
    vec_t v = v_idle(n);
    v.en = 1; v.csr_op = 1; v.f3 = f3; v.a = a; v.rs1a = rs1a; v.val = val;
    v.rdw = 1; v.rda = 5'd5; v.x_rdw = 1; v.chk_rd = 1; v.x_rd = exp; v.x_rda = 5'd5;
    return v;
  endfunction

  function automatic vec_t v_rd(input string n, input logic [11:0] a, input logic [63:0] exp);
    vec_t v = v_csr(n, 3'b010, a, 5'd0, 64'hDEAD_BEEF, exp);
    v.rda = 5'd6; v.x_rda = 5'd6;
    return v;
  endfunction

  function automatic vec_t v_evt(input string n, input bit ec, input bit eb, input bit il,
                                 input bit mr, input logic [63:0] p, input bit xr,
                                 input logic [63:0] xa, input int mg);
    vec_t v = v_idle(n);
    v.en = 1; v.ecall = ec; v.ebreak = eb; v.illegal = il; v.mret = mr; v.pc = p;
    v.x_redir = xr; v.x_raddr = xa; v.x_mg = mg;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    sb_t e;
    rst_n = ~v.rst; en = v.en; csr_op = v.csr_op; func3 = v.f3; csr_a = v.a; rs1_a = v.rs1a;
    rs1_val = v.val; rd_a = v.rda; rd_w = v.rdw; pc = v.pc; ecall = v.ecall;
    ebreak = v.ebreak; illegal = v.illegal; mret = v.mret; retire = v.retire; mtip = v.mtip;
    #1;
    if (!v.rst) begin
      chk({v.name, ".redirect"}, 64'(redirect), 64'(v.x_redir));
      if (v.x_redir) chk({v.name, ".redirect_addr"}, redirect_addr, v.x_raddr);
    end
    e.name = v.name; e.rdw = v.x_rdw; e.chk = v.chk_rd; e.rd = v.x_rd; e.rda = v.x_rda;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.name, ".rd_w_o"}, 64'(rd_w_o), 64'(e.rdw));
    if (e.chk) begin
      chk({e.name, ".rd_o"}, rd_o, e.rd);
      chk({e.name, ".rd_a_o"}, 64'(rd_a_o), 64'(e.rda));
    end
    if (v.x_mg >= 0) chk({v.name, ".mie_global"}, 64'(mie_global), 64'(v.x_mg));
    $display("[%0t] %-14s rd_w_o=%0b rd_a_o=%0d rd_o=%h mie=%0b", $time, v.name, rd_w_o,
             rd_a_o, rd_o, mie_global);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    rst_n = 0; en = 0; csr_op = 0; func3 = 0; csr_a = 0; rs1_a = 0; rs1_val = 0; rd_a = 0;
    rd_w = 0; pc = 0; ecall = 0; ebreak = 0; illegal = 0; mret = 0; retire = 0; mtip = 0;

    // Main table: CSR ops, WARL, traps and mret.
    tbl.push_back(v_rd("rd_mstatus0", 12'h300, MS_RST));
    tbl.push_back(v_rd("rd_mtvec0", 12'h305, 64'h0));
    tbl.push_back(v_csr("rw_mtvec", 3'b001, 12'h305, 5'd7, 64'h8000_1003, 64'h0));
    tbl.push_back(v_rd("rd_mtvec", 12'h305, 64'h8000_1000));
    tbl.push_back(v_csr("rw_mscratch", 3'b001, 12'h340, 5'd7, 64'h0F, 64'h0));
    tbl.push_back(v_csr("rs_mscratch", 3'b010, 12'h340, 5'd7, 64'hF0, 64'h0F));
    tbl.push_back(v_csr("rc_mscratch", 3'b011, 12'h340, 5'd7, 64'h3C, 64'hFF));
    tbl.push_back(v_csr("rs_x0_noop", 3'b010, 12'h340, 5'd0, 64'hFFFF, 64'hC3));
    tbl.push_back(v_rd("rd_mscratch", 12'h340, 64'hC3));
    v = v_csr("rsi_mstatus", 3'b110, 12'h300, 5'd8, 64'h0, MS_RST); v.x_mg = 1; tbl.push_back(v);
    tbl.push_back(v_rd("rd_mstatus1", 12'h300, MS_RST | 64'h8));
    tbl.push_back(v_csr("rw_mie", 3'b001, 12'h304, 5'd7, '1, 64'h0));
    tbl.push_back(v_rd("rd_mie", 12'h304, 64'h80));
    tbl.push_back(v_rd("rd_mhartid", 12'hF14, 64'h3));
    tbl.push_back(v_csr("rw_mhartid", 3'b001, 12'hF14, 5'd7, 64'hFF, 64'h3));
    tbl.push_back(v_rd("rd_mhartid2", 12'hF14, 64'h3));
    tbl.push_back(v_csr("rw_unimpl", 3'b001, 12'h7C0, 5'd7, 64'h55, 64'h0));
    tbl.push_back(v_rd("rd_unimpl", 12'h7C0, 64'h0));
    tbl.push_back(v_csr("rw_mepc", 3'b001, 12'h341, 5'd7, 64'h1237, 64'h0));
    tbl.push_back(v_rd("rd_mepc", 12'h341, 64'h1234));
    tbl.push_back(v_evt("ecall", 1, 0, 0, 0, 64'h8000_0010, 1, 64'h8000_1000, 0));
    tbl.push_back(v_rd("rd_mepc_ec", 12'h341, 64'h8000_0010));
    tbl.push_back(v_rd("rd_mcause_ec", 12'h342, 64'd11));
    tbl.push_back(v_rd("rd_mstatus_ec", 12'h300, MS_RST | 64'h80));
    tbl.push_back(v_evt("mret", 0, 0, 0, 1, 64'h8000_1004, 1, 64'h8000_0010, 1));
    tbl.push_back(v_rd("rd_mstatus_mr", 12'h300, MS_RST | 64'h88));
    tbl.push_back(v_evt("ill_eb_ec", 1, 1, 1, 0, 64'h8000_0020, 1, 64'h8000_1000, 0));
    tbl.push_back(v_rd("rd_mcause_il", 12'h342, 64'd2));
    tbl.push_back(v_evt("eb_ec", 1, 1, 0, 0, 64'h8000_0024, 1, 64'h8000_1000, 0));
    tbl.push_back(v_rd("rd_mcause_eb", 12'h342, 64'd3));
    tbl.push_back(v_evt("mret_mpie0", 0, 0, 0, 1, 64'h8000_1008, 1, 64'h8000_0024, 0));
    tbl.push_back(v_rd("rd_mstatus_m2", 12'h300, MS_RST | 64'h80));
    v = v_csr("rsi_mstatus2", 3'b110, 12'h300, 5'd8, 64'h0, MS_RST | 64'h80); v.x_mg = 1;
    tbl.push_back(v);
    tbl.push_back(v_evt("ecall_mret", 1, 0, 0, 1, 64'h8000_0030, 1, 64'h8000_1000, 0));
    tbl.push_back(v_rd("rd_mepc_em", 12'h341, 64'h8000_0030));
    v = v_csr("rsi_mstatus3", 3'b110, 12'h300, 5'd8, 64'h0, MS_RST | 64'h80); v.x_mg = 1;
    tbl.push_back(v);
    v = v_csr("irq_ec_rw", 3'b001, 12'h340, 5'd7, 64'h1111, 64'h0);
    v.mtip = 1; v.ecall = 1; v.pc = 64'h8000_0040; v.x_redir = 1; v.x_raddr = 64'h8000_1000;
    v.x_rdw = 0; v.chk_rd = 0; v.x_mg = 0; tbl.push_back(v);
    tbl.push_back(v_rd("rd_mscr_irq", 12'h340, 64'hC3));
    tbl.push_back(v_rd("rd_mcause_irq", 12'h342, 64'h8000_0000_0000_0007));
    tbl.push_back(v_rd("rd_mepc_irq", 12'h341, 64'h8000_0040));
    tbl.push_back(v_rd("rd_mstat_irq", 12'h300, MS_RST | 64'h80));
    v = v_rd("rd_mip", 12'h344, 64'h80); v.mtip = 1; tbl.push_back(v);
    v = v_evt("no_csr_op", 0, 0, 0, 0, 64'h0, 0, 64'h0, -1); v.rdw = 1; tbl.push_back(v);
    tbl.push_back(v_idle("idle"));
    // Reset coincident with an enabled interrupt, ecall and CSR write.
    v = v_csr("rsi_mstatus4", 3'b110, 12'h300, 5'd8, 64'h0, MS_RST | 64'h80); v.x_mg = 1;
    tbl.push_back(v);
    v = v_csr("rst_trap", 3'b001, 12'h340, 5'd7, 64'h7777, 64'h0);
    v.rst = 1; v.mtip = 1; v.ecall = 1; v.pc = 64'h8000_0050; v.x_rdw = 0; v.x_rda = 5'd0;
    v.x_mg = 0; tbl.push_back(v);
    tbl.push_back(v_rd("rd_mstatus_r", 12'h300, MS_RST));
    tbl.push_back(v_rd("rd_mie_r", 12'h304, 64'h0));
    tbl.push_back(v_rd("rd_mtvec_r", 12'h305, 64'h0));
    tbl.push_back(v_rd("rd_mscratch_r", 12'h340, 64'h0));
    tbl.push_back(v_rd("rd_mepc_r", 12'h341, 64'h0));
    tbl.push_back(v_rd("rd_mcause_r", 12'h342, 64'h0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.rd_o", rd_o, 64'h0);
    chk("reset.rd_w_o", 64'(rd_w_o), 64'h0);
    chk("reset.rd_a_o", 64'(rd_a_o), 64'h0);
    chk("reset.mie_global", 64'(mie_global), 64'h0);

    foreach (tbl[i]) apply(tbl[i]);

`ifdef CSR_COUNTERS_EN
    // mcycle wraps from all-ones to 0 on the cycle after the write.
    v = v_csr("rw_mcycle", 3'b001, 12'hB00, 5'd7, '1, 64'h0); v.chk_rd = 0; apply(v);
    apply(v_idle("cyc_idle"));
    apply(v_rd("rd_mcycle", 12'hB00, 64'h0));
    v = v_csr("rw_minstret", 3'b001, 12'hB02, 5'd7, 64'h0, 64'h0); v.chk_rd = 0; apply(v);
    for (int k = 0; k < 5; k++) begin
      v = v_evt("retire", 0, 0, 0, 0, 64'h0, 0, 64'h0, -1); v.retire = 1; apply(v);
    end
    v = v_idle("no_retire"); v.retire = 1; apply(v);
    apply(v_rd("rd_minstret", 12'hB02, 64'd5));
`else
    apply(v_csr("rw_mcycle_off", 3'b001, 12'hB00, 5'd7, 64'h5, 64'h0));
    apply(v_rd("rd_mcycle_off", 12'hB00, 64'h0));
`endif

    if (sbq.size() != 0) chk("scoreboard_drain", 64'(sbq.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Parametrised machine-mode CSR file and trap controller for the single-issue core.
- Executes Zicsr ops (register and immediate forms) with correct set/clear semantics.
- Sequences trap entry (ecall, ebreak, illegal, machine timer interrupt) and mret, updating mstatus.MIE/MPIE/MPP and producing the PC redirect.
- Sits beside the execute stage; writeback is registered.

Parameters:
XLEN, 64, datapath and CSR width (32 or 64).
MSTATUS_RST, 64'h0000_000a_0000_1800, mstatus reset value, truncated to XLEN.
MTVEC_RST, 0, mtvec reset value.
HART_ID, 0, value returned by mhartid.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  instruction valid this cycle; all updates are qualified by en, except counters and interrupt sampling
csr_op  in  1  instruction is a Zicsr op
func3  in  3  001 rw, 010 rs, 011 rc, 101 rwi, 110 rsi, 111 rci
csr_a  in  12  CSR address
rs1_a  in  5  rs1 index; also the uimm source for immediate forms
rs1_val  in  XLEN  forwarded rs1 value
rd_a  in  5  destination index
rd_w  in  1  destination write request
pc  in  XLEN  PC of the current instruction
ecall  in  1  ecall decoded
ebreak  in  1  ebreak decoded
illegal  in  1  illegal instruction decoded
mret  in  1  mret decoded
retire  in  1  instruction retires this cycle (minstret)
mtip  in  1  machine timer interrupt pending, level
rd_o  out  XLEN  registered CSR read data
rd_w_o  out  1  registered writeback enable
rd_a_o  out  5  registered writeback index
redirect  out  1  combinational PC redirect
redirect_addr  out  XLEN  redirect target
mie_global  out  1  mstatus.MIE, for debug

Behaviour:
- Implemented CSRs:
  - mstatus 0x300, mie 0x304 (only MTIE bit 7 is writable), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
  - mip 0x344 is read-only; MTIP mirrors mtip.
  - mhartid 0xF14 is read-only and returns HART_ID.
  - Any other address reads 0 and ignores writes.
- Operand: src = rs1_val for func3[2]=0; src = zero-extended rs1_a for func3[2]=1.
- Read-modify-write:
  - Read value is the pre-write CSR value.
  - rw: new = src.
  - rs: new = old | src.
  - rc: new = old & ~src.
  - rs/rc with rs1_a==0 perform no write; side-effect-free read.
  - Writes to read-only CSRs are ignored.
- WARL rules:
  - mtvec[1:0] reads 0 (direct mode only).
  - mepc[1:0] reads 0.
  - mstatus.MPP reads 2'b11.
- Writeback:
  - Registered one cycle after en: rd_o, rd_a_o, and rd_w_o = rd_w & csr_op.
  - rd_w_o = 0 on cycles without en.
  - rd_w_o = 0 when a trap is taken that cycle.
- Trap entry, in priority order:
  - Priority: interrupt (mstatus.MIE & mie.MTIE & mtip & en) > illegal > ebreak > ecall.
  - mcause: {1, 63'd7} for interrupt, 2 for illegal, 3 for ebreak, 11 for ecall. The top bit is XLEN-1.
  - mepc <= pc.
  - MPIE <= MIE; MIE <= 0; MPP <= 11.
  - redirect = 1, redirect_addr = mtvec.
- mret (no trap same cycle):
  - MIE <= MPIE; MPIE <= 1.
  - redirect = 1, redirect_addr = mepc.
- Simultaneous events:
  - A trap suppresses that cycle's CSR write and mret.
  - A CSR write to mstatus in the same cycle as an interrupt is discarded.
- Reset:
  - mstatus = MSTATUS_RST, mtvec = MTVEC_RST.
  - mie, mscratch, mepc, mcause = 0.
  - rd_o = 0, rd_w_o = 0, rd_a_o = 0.
  - Reset asserted mid-operation overrides every pending update that cycle.

Optional Feature:
CSR_COUNTERS_EN
- Defined:
  - mcycle 0xB00 increments every cycle.
  - minstret 0xB02 increments when en & retire.
  - Both are XLEN wide, wrap at all-ones to 0, and reset to 0.
  - A CSR write in the same cycle overrides the increment.
  - For XLEN=32, mcycleh 0xB80 and minstreth 0xB82 exist and the counters are 64 bit.
- Undefined: these addresses behave as unimplemented (read 0, writes ignored).

Decomposition:
- Shared package csr_pkg:
  - CSR address localparams.
  - Cause codes: 2, 3, 11, 7.
  - func3 encodings.
  - mstatus bit positions: MIE 3, MPIE 7, MPP 12:11.
- One sub-module: csr_trap_ctrl, which does priority encoding and computes cause, redirect and the trap/mret mstatus next-state.

Test Plan:
- Reset, then csrrw x5,mtvec with rs1=0x8000_1003 -> rd_o = 0 next cycle; mtvec reads 0x8000_1000.
- csrrs x6,mscratch with src=0xF0 after mscratch=0x0F -> rd_o = 0x0F, mscratch = 0xFF. Then csrrc with 0x3C -> mscratch = 0xC3. Then csrrs with rs1_a=0 -> no write.
- ecall at pc=0x8000_0010 with mtvec=0x8000_1000, MIE=1 -> redirect=1, addr 0x8000_1000, mepc 0x8000_0010, mcause 11, MIE 0, MPIE 1. Then mret -> redirect to 0x8000_0010, MIE 1.
- mtip=1 with MIE=1, MTIE=1, and an ecall plus csrrw mscratch in the same cycle -> mcause 0x8000_0000_0000_0007, mscratch unchanged, rd_w_o = 0.
- Assert rst_n=0 coincident with a trap -> all CSRs at reset values, redirect ignored, rd_w_o = 0.
- With CSR_COUNTERS_EN: write mcycle = all-ones -> reads 0 two cycles later. minstret counts exactly 5 for 5 en&retire pulses.
